subinst_rr_scheduler: RTL and testbench

SUBINST_RR_SCHEDULER -- requirements
Module: subinst_rr_scheduler

---
 rtl/subinst_rr_scheduler_pkg.sv | 21 ++
 rtl/subinst_rr_scheduler_rr_pick.sv | 29 ++
 rtl/subinst_rr_scheduler.sv | 116 +++++++++++
 tb/tb_subinst_rr_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/subinst_rr_scheduler_pkg.sv
// Shared types and defaults for the sub-instance round-robin scheduler.
// Holds the FSM state encoding, default sizing and the id-width helper.
package subinst_rr_scheduler_pkg;

    localparam int N_REQ_DEF   = 5;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Keeps the id bus at least one bit wide for a single requester.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W_DEF = id_width(N_REQ_DEF);

endpackage

// File: rtl/subinst_rr_scheduler_rr_pick.sv
// Rotating priority pick: first set request bit scanning from start upward, wrapping.
// Purely combinational; no backpressure.
module rr_pick #(
    parameter int N_REQ = 5,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  start,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = int'(start) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/subinst_rr_scheduler.sv
// Round-robin grant FSM for N_REQ sub-instances sharing one resource.
// Latency: req to grant 1 cycle; grant held until done, request drop or TIMEOUT, then 2 idle cycles.
module subinst_rr_scheduler
    import subinst_rr_scheduler_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0]              done,
    output logic [N_REQ-1:0]              grant,
    output logic [id_width(N_REQ)-1:0]    grant_id,
    output logic                          grant_valid,
    output logic                          timeout_pulse,
    output logic [id_width(N_REQ)-1:0]    rr_ptr
);

    localparam int ID_W  = id_width(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [CNT_W-1:0] hold_cnt;
    logic             to_flag;
    logic             own_done;
    logic             own_req;
    logic             hold_expire;
    logic             grant_exit;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Only the granted requester's done/req bits can end a grant.
    assign own_done    = done[cur_id];
    assign own_req     = req[cur_id];
    assign hold_expire = (hold_cnt == CNT_W'(TIMEOUT - 1));
    assign grant_exit  = own_done || !own_req || hold_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (pick_found) state_nxt = ST_GRANT;
            ST_GRANT:   if (grant_exit) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id   <= '0;
            hold_cnt <= '0;
            to_flag  <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        cur_id   <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != CNT_W'(TIMEOUT)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    // A coincident done (or request drop) takes precedence over timeout.
                    to_flag <= hold_expire && !own_done && own_req;
                end
                ST_RELEASE: begin
                    to_flag <= 1'b0;
                    rr_ptr  <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + 1'b1;
                end
                default: begin
                    to_flag <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        grant         = '0;
        grant_id      = '0;
        grant_valid   = 1'b0;
        timeout_pulse = 1'b0;
        if (state == ST_GRANT) begin
            grant[cur_id] = 1'b1;
            grant_id      = cur_id;
            grant_valid   = 1'b1;
        end
        if (state == ST_RELEASE) begin
            timeout_pulse = to_flag;
        end
    end

endmodule

// File: tb/tb_subinst_rr_scheduler.sv
// Directed and randomized bench for subinst_rr_scheduler (N_REQ=5, TIMEOUT=16).
module tb_subinst_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       timeout_pulse;
    logic [2:0] rr_ptr;

    int errors = 0;
    int checks = 0;
    int wait_cnt [5];

    always #5 clk = ~clk;

    subinst_rr_scheduler #(
        .N_REQ   (5),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .done          (done),
        .grant         (grant),
        .grant_id      (grant_id),
        .grant_valid   (grant_valid),
        .timeout_pulse (timeout_pulse),
        .rr_ptr        (rr_ptr)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [4:0] eg, input logic [2:0] eid,
                           input logic ev, input logic etp);
        check({tag, ".grant"},         32'(grant),         32'(eg));
        check({tag, ".grant_id"},      32'(grant_id),      32'(eid));
        check({tag, ".grant_valid"},   32'(grant_valid),   32'(ev));
        check({tag, ".timeout_pulse"}, 32'(timeout_pulse), 32'(etp));
    endtask

    // Entered one negedge after the grant edge; leaves at the IDLE cycle after RELEASE.
    task automatic serve(input int id, input int hold, input logic [2:0] ptr_after);
        logic [4:0] oh;
        oh = 5'b00001 << id;
        chk_out("serve_grant", oh, 3'(id), 1'b1, 1'b0);
        repeat (hold - 1) tick();
        chk_out("serve_hold", oh, 3'(id), 1'b1, 1'b0);
        done = oh;
        tick();
        done = '0;
        chk_out("serve_release", 5'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk_out("serve_idle", 5'b0, 3'd0, 1'b0, 1'b0);
        check("serve_rr_ptr", 32'(rr_ptr), 32'(ptr_after));
    endtask

    initial begin
        int         ids  [4];
        logic [2:0] ptrs [4];
        logic       prev_vld;
        logic [4:0] oh_exp;

        rst  = 1'b1;
        req  = '0;
        done = 5'b11111;
        tick();
        tick();
        chk_out("reset", 5'b0, 3'd0, 1'b0, 1'b0);
        check("reset_rr_ptr", 32'(rr_ptr), 32'd0);
        rst  = 1'b0;
        done = '0;
        tick();
        tick();
        chk_out("idle_no_req", 5'b0, 3'd0, 1'b0, 1'b0);

        // Round robin over requesters 0,2,4
        req  = 5'b10101;
        ids  = '{0, 2, 4, 0};
        ptrs = '{3'd1, 3'd3, 3'd0, 3'd1};
        tick();
        for (int i = 0; i < 4; i++) begin
            serve(ids[i], 3, ptrs[i]);
            if (i == 3) req = '0;
            tick();
        end
        chk_out("idle_after_rr", 5'b0, 3'd0, 1'b0, 1'b0);

        // Foreign done and other req changes do not disturb grant 4
        req = 5'b10000;
        tick();
        chk_out("g4_start", 5'b10000, 3'd4, 1'b1, 1'b0);
        done = 5'b00010;
        req  = 5'b11110;
        tick();
        done = '0;
        chk_out("g4_foreign_done", 5'b10000, 3'd4, 1'b1, 1'b0);
        tick();
        serve(4, 1, 3'd0);
        req = '0;
        tick();

        // Timeout on requester 3, then re-grant
        req = 5'b01000;
        tick();
        chk_out("to_g1", 5'b01000, 3'd3, 1'b1, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk_out("to_hold", 5'b01000, 3'd3, 1'b1, 1'b0);
        end
        tick();
        chk_out("to_release", 5'b0, 3'd0, 1'b0, 1'b1);
        tick();
        chk_out("to_idle", 5'b0, 3'd0, 1'b0, 1'b0);
        check("to_rr_ptr", 32'(rr_ptr), 32'd4);
        tick();
        chk_out("to_regrant", 5'b01000, 3'd3, 1'b1, 1'b0);

        // done coincides with timeout in the 16th grant cycle
        repeat (15) tick();
        chk_out("co_g16", 5'b01000, 3'd3, 1'b1, 1'b0);
        done = 5'b01000;
        tick();
        done = '0;
        req  = '0;
        chk_out("co_release", 5'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("co_rr_ptr", 32'(rr_ptr), 32'd4);

        // Requester drops its request mid-grant
        req = 5'b00010;
        tick();
        chk_out("drop_grant", 5'b00010, 3'd1, 1'b1, 1'b0);
        req = '0;
        tick();
        chk_out("drop_release", 5'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("drop_rr_ptr", 32'(rr_ptr), 32'd2);

        // Reset during a grant to requester 2
        req = 5'b00100;
        tick();
        chk_out("rst_pre", 5'b00100, 3'd2, 1'b1, 1'b0);
        tick();
        rst  = 1'b1;
        done = 5'b00100;
        tick();
        chk_out("rst_mid", 5'b0, 3'd0, 1'b0, 1'b0);
        check("rst_mid_rr_ptr", 32'(rr_ptr), 32'd0);
        rst  = 1'b0;
        done = '0;
        tick();
        chk_out("rst_regrant", 5'b00100, 3'd2, 1'b1, 1'b0);
        done = 5'b00100;
        req  = '0;
        tick();
        done = '0;
        tick();
        check("rst_after_rr_ptr", 32'(rr_ptr), 32'd3);

        // All requesting from pointer 3: wraps 3,4,0,1
        req  = 5'b11111;
        ids  = '{3, 4, 0, 1};
        ptrs = '{3'd4, 3'd0, 3'd1, 3'd2};
        tick();
        for (int i = 0; i < 4; i++) begin
            serve(ids[i], 1, ptrs[i]);
            if (i == 3) req = '0;
            tick();
        end

        // Random traffic: one-hot invariant and bounded wait
        for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
        prev_vld = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            check("rand_onehot", 32'($onehot0(grant)), 32'd1);
            oh_exp = grant_valid ? (5'b00001 << grant_id) : 5'b0;
            check("rand_grant_vs_id", 32'(grant), 32'(oh_exp));
            check("rand_valid", 32'(grant_valid), 32'(|grant));
            for (int i = 0; i < 5; i++) begin
                if (!req[i]) begin
                    wait_cnt[i] = 0;
                end else if (grant_valid && !prev_vld) begin
                    if (grant_id == 3'(i)) begin
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                        check("rand_starve", 32'(wait_cnt[i] > 4), 32'd0);
                    end
                end
            end
            prev_vld = grant_valid;
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(15) == 0) req[i] = ~req[i];
            end
            done = 5'($urandom) & 5'($urandom);
        end

        req  = '0;
        done = '0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
